// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that fills the fetch-side instruction memory
module imem_loader #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 4,
  parameter int WORD_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              abort,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              busy,
  output logic              start,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] asm_reg;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] count;

  logic              count_legal;
  logic              byte_xfer;
  logic              mem_we;
  logic              rd_in_range;

  // A count of zero or anything beyond the array is rejected before a load starts.
  assign count_legal = (load_words != '0) && ({1'b0, load_words} <= DEPTH_EXT);

  // byte_ready is registered and high only in RECV, so it doubles as the RECV qualifier.
  assign byte_xfer = byte_ready && byte_valid && !abort;

  // Abort during WRITE suppresses the commit of the assembled word.
  assign mem_we = (state == WRITE) && !abort;

  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);

  // Fetch read port: combinational, out-of-range addresses read as zero.
  always_comb begin
    rd_data = '0;
    if (rd_in_range) begin
      rd_data = mem[rd_addr[IDX_W-1:0]];
    end
  end

  // Instruction array: cleared by reset, written once per WRITE cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[word_idx[IDX_W-1:0]] <= asm_reg;
    end
  end

  // Load sequencer: count check, byte assembly, word commit and the start pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      asm_reg      <= '0;
      byte_idx     <= '0;
      word_idx     <= '0;
      count        <= '0;
      byte_ready   <= 1'b0;
      busy         <= 1'b0;
      start        <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: begin
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          if (load_en) begin
            if (count_legal) begin
              count        <= load_words;
              word_idx     <= '0;
              byte_idx     <= '0;
              words_loaded <= '0;
              error        <= 1'b0;
              byte_ready   <= 1'b1;
              busy         <= 1'b1;
              state        <= RECV;
            end else begin
              error <= 1'b1;
            end
          end
        end

        RECV: begin
          if (abort) begin
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            byte_idx   <= '0;
            state      <= IDLE;
          end else if (byte_xfer) begin
            asm_reg  <= {asm_reg[WORD_W-9:0], byte_in};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              byte_ready <= 1'b0;
              state      <= WRITE;
            end
          end
        end

        WRITE: begin
          byte_idx <= '0;
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            words_loaded <= words_loaded + 1'b1;
            if (word_idx == count - 1'b1) begin
              busy  <= 1'b0;
              start <= 1'b1;
              state <= DONE;
            end else begin
              word_idx   <= word_idx + 1'b1;
              byte_ready <= 1'b1;
              state      <= RECV;
            end
          end
        end

        DONE: begin
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction memory that the fetch stage reads. Accepts a program as a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Writes the words into an internal DEPTH-entry instruction array starting at address 0. Exposes a combinational read port for fetch, and pulses `start` for one cycle when the load completes, which launches the pipeline.

Parameters:
DEPTH, 8, number of 32-bit instruction words held
ADDR_W, 4, width of the read address and of load_words (matches the fetch PC width)
WORD_W, 32, instruction width (fixed at 4 bytes; other values are not supported)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
load_en  input  1  request to begin a load; sampled only in IDLE
load_words  input  ADDR_W  number of words to load; legal range 1..DEPTH
byte_in  input  8  program byte; the first byte of each word is the MSB
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader will accept byte_in this cycle
abort  input  1  synchronous cancel of an in-progress load
rd_addr  input  ADDR_W  fetch read address
rd_data  output  WORD_W  instruction at rd_addr (combinational)
busy  output  1  a load is in progress (RECV or WRITE)
start  output  1  one-cycle pulse when the load completes
error  output  1  sticky flag for an illegal load_words value
words_loaded  output  ADDR_W  count of words committed by the current or last load

Behaviour:
- Reset (asynchronous, active-high):
  - state goes to IDLE.
  - all memory words, the assembly register, and byte/word indices are cleared to 0.
  - byte_ready, busy, start, error = 0; words_loaded = 0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - byte_ready = 0, busy = 0.
  - On load_en = 1 with 1 <= load_words <= DEPTH:
    - latch the count; clear word_idx, byte_idx and words_loaded; clear error.
    - enter RECV on the next edge.
  - On load_en = 1 with load_words = 0 or > DEPTH: set error = 1, stay in IDLE, leave memory untouched.
- RECV:
  - byte_ready = 1, busy = 1.
  - A byte transfers when byte_valid && byte_ready at a rising edge:
    - assembly register <= {asm[23:0], byte_in}.
    - byte_idx increments.
  - After the 4th byte is accepted, go to WRITE. byte_ready is 0 in WRITE.
  - With byte_valid = 0, the loader holds state indefinitely; there is no timeout.
- WRITE (exactly one cycle):
  - mem[word_idx] <= asm; words_loaded increments; byte_idx resets.
  - If this was word count-1, go to DONE; otherwise increment word_idx and return to RECV.
- DONE:
  - start = 1 for exactly this one cycle; busy = 0.
  - Return to IDLE on the next edge.
  - Memory, words_loaded and error hold until the next load or reset.
- Throughput: minimum 5 cycles per word (4 byte transfers + 1 write). A load of N words with byte_valid held high:
  - start asserts 5N+1 cycles after the load_en edge.
- abort:
  - In RECV or WRITE: return to IDLE at the next edge.
  - The partial word is discarded and words already written stay in memory; words_loaded reflects the committed words.
  - No start pulse is produced.
  - If abort coincides with the WRITE cycle, abort wins and that word is not written.
  - abort in IDLE or DONE has no effect; the DONE start pulse still occurs.
- load_en while busy or in DONE is ignored.
- Read port:
  - rd_data = mem[rd_addr] combinationally.
  - rd_addr >= DEPTH returns 0.
  - A read of the address being written in the WRITE cycle returns the old value; the new value is visible from the following cycle.
- Words beyond count-1 keep their previous contents; a load never clears them.
- Reset asserted mid-load: everything returns to the reset state immediately, including memory contents.

Test Plan:
- Basic load:
  - Stimulus: load_en, load_words=2; bytes 0x20,0x01,0x00,0x05,0x00,0x22,0x18,0x20 with byte_valid held high.
  - Required: rd_addr=0 reads 0x20010005; rd_addr=1 reads 0x00221820; start pulses once, on cycle 11 after load_en; words_loaded=2.
- Backpressure:
  - Stimulus: same load with byte_valid toggling 1/0 every cycle.
  - Required: identical memory contents; byte_ready is never 1 in WRITE; no byte is dropped or duplicated.
- Illegal count:
  - Stimulus: load_words=0, then load_words=9.
  - Required: error=1 both times; state stays IDLE; memory unchanged; a following legal load_words=1 clears error.
- Abort:
  - Stimulus: load_words=3; abort after 6 bytes.
  - Required: mem[0] holds word 0; mem[1] unchanged; words_loaded=1; no start pulse; byte_ready=0 the next cycle.
- Full depth and read edge cases:
  - Stimulus: load 8 words 0x00000000..0x00000007, then read rd_addr=7 and rd_addr=15.
  - Required: rd_addr=7 reads 0x00000007; rd_addr=15 reads 0x00000000.
- Async reset mid-word:
  - Stimulus: assert reset between clock edges after 2 bytes of word 0.
  - Required: immediately busy=0, byte_ready=0, all memory reads 0; a subsequent load completes normally.
